// File: rtl/transform_pkg.sv
// Shared definitions for the tilt perspective-mapping datapath and its scan sequencer.
package transform_pkg;

  localparam int unsigned COORD_W    = 11;
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned SETTLE_W   = 4;
  localparam int unsigned BOARD_SIZE = 480;
  localparam int unsigned CENTER     = 240;

  localparam logic [COORD_W-1:0] OOB_MARK = 11'b100_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SCAN   = 3'd3,
    ST_DRAIN  = 3'd4
  } scan_state_e;

  // One output beat: source coordinate, mapped coordinate and flags.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;
    logic               oob;
    logic               last;
  } beat_t;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y counter: x runs fastest, wraps at WIDTH-1 and carries into y.
module raster_counter
  import transform_pkg::*;
#(
  parameter int unsigned WIDTH  = BOARD_SIZE,
  parameter int unsigned HEIGHT = BOARD_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             last
);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             w_x_end;
  logic             w_y_end;

  assign w_x_end = (r_x == CNT_W'(WIDTH - 1));
  assign w_y_end = (r_y == CNT_W'(HEIGHT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (step) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + CNT_W'(1);
      end else begin
        r_x <= r_x + CNT_W'(1);
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign last = w_x_end && w_y_end;

endmodule

// File: rtl/transform_scan_ctrl.sv
// Frame sequencer: latches one tilt sample per frame, raster-scans the board through
// the mapping datapath and streams mapped coordinates out over valid/ready.
module transform_scan_ctrl
  import transform_pkg::*;
#(
  parameter int unsigned WIDTH         = BOARD_SIZE,
  parameter int unsigned HEIGHT        = BOARD_SIZE,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               tilt_valid,
  output logic               tilt_ready,
  input  logic [COORD_W-1:0] tilt_sin_x,
  input  logic [COORD_W-1:0] tilt_sin_y,
  output logic [COORD_W-1:0] map_sin_x,
  output logic [COORD_W-1:0] map_sin_y,
  output logic [COORD_W-1:0] map_x,
  output logic [COORD_W-1:0] map_y,
  input  logic [COORD_W-1:0] map_x_out,
  input  logic [COORD_W-1:0] map_y_out,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COORD_W-1:0] pix_tx,
  output logic [COORD_W-1:0] pix_ty,
  output logic               pix_oob,
  output logic               pix_last,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_overrun
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD   = ST_LOAD;
  localparam logic [2:0] S_SETTLE = ST_SETTLE;
  localparam logic [2:0] S_SCAN   = ST_SCAN;
  localparam logic [2:0] S_DRAIN  = ST_DRAIN;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [SETTLE_W-1:0] r_settle;
  logic [COORD_W-1:0]  r_shadow_x;
  logic [COORD_W-1:0]  r_shadow_y;
  logic [COORD_W-1:0]  r_act_x;
  logic [COORD_W-1:0]  r_act_y;
  beat_t               r_beat;
  logic                r_pix_valid;

  logic [CNT_W-1:0]    w_cnt_x;
  logic [CNT_W-1:0]    w_cnt_y;
  logic                w_last;
  logic                w_scan;
  logic                w_adv;
  logic                w_hs;

  assign w_scan = (r_state == S_SCAN);
  assign w_adv  = !r_pix_valid || pix_ready;
  assign w_hs   = r_pix_valid && pix_ready;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk   (clk),
    .rst   (rst),
    .clear (r_state == S_LOAD),
    .step  (w_scan && w_adv),
    .x     (w_cnt_x),
    .y     (w_cnt_y),
    .last  (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (frame_start) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_settle == SETTLE_W'(1)) w_state_nxt = S_SCAN;
      S_SCAN:   if (w_adv && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_hs && r_beat.last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Shadow takes every offered sample; active only updates in LOAD (with bypass).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_x <= '0;
      r_shadow_y <= '0;
      r_act_x    <= '0;
      r_act_y    <= '0;
      r_settle   <= '0;
    end else begin
      if (tilt_valid) begin
        r_shadow_x <= tilt_sin_x;
        r_shadow_y <= tilt_sin_y;
      end
      if (r_state == S_LOAD) begin
        r_act_x  <= tilt_valid ? tilt_sin_x : r_shadow_x;
        r_act_y  <= tilt_valid ? tilt_sin_y : r_shadow_y;
        r_settle <= SETTLE_W'(SETTLE_CYCLES);
      end else if (r_state == S_SETTLE) begin
        r_settle <= r_settle - SETTLE_W'(1);
      end
    end
  end

  // Beat register: captures in SCAN when free, otherwise only empties on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat      <= '0;
      r_pix_valid <= 1'b0;
    end else if (w_scan && w_adv) begin
      r_beat.x    <= map_x;
      r_beat.y    <= map_y;
      r_beat.tx   <= map_x_out;
      r_beat.ty   <= map_y_out;
      r_beat.oob  <= map_x_out[COORD_W-1] | map_y_out[COORD_W-1];
      r_beat.last <= w_last;
      r_pix_valid <= 1'b1;
    end else if (w_hs) begin
      r_pix_valid <= 1'b0;
    end
  end

  assign tilt_ready    = 1'b1;
  assign map_sin_x     = r_act_x;
  assign map_sin_y     = r_act_y;
  assign map_x         = COORD_W'(w_cnt_x);
  assign map_y         = COORD_W'(w_cnt_y);
  assign pix_valid     = r_pix_valid;
  assign pix_x         = r_beat.x;
  assign pix_y         = r_beat.y;
  assign pix_tx        = r_beat.tx;
  assign pix_ty        = r_beat.ty;
  assign pix_oob       = r_beat.oob;
  assign pix_last      = r_beat.last;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = (r_state == S_DRAIN) && w_hs && r_beat.last;
  assign frame_overrun = frame_start && (r_state != S_IDLE);

endmodule

// File: tb/tb_transform_scan_ctrl.sv
// Directed bench for transform_scan_ctrl on a reduced 8x4 board with a simple datapath model.
module tb_transform_scan_ctrl;

  localparam int unsigned W      = 8;
  localparam int unsigned H      = 4;
  localparam int unsigned S      = 1;
  localparam int unsigned OOB_X  = 5;
  localparam int unsigned BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, tilt_valid, tilt_ready;
  logic [10:0] tilt_sin_x, tilt_sin_y, map_sin_x, map_sin_y, map_x, map_y;
  logic [10:0] map_x_out, map_y_out;
  logic        pix_valid, pix_ready;
  logic [10:0] pix_x, pix_y, pix_tx, pix_ty;
  logic        pix_oob, pix_last, busy, frame_done, frame_overrun;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Datapath stand-in: x >= OOB_X is out of bound, otherwise fixed offsets.
  assign map_x_out = (map_x >= 11'(OOB_X)) ? 11'h400 : map_x + 11'd16;
  assign map_y_out = map_y + 11'd32;

  transform_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .tilt_valid(tilt_valid),
    .tilt_ready(tilt_ready), .tilt_sin_x(tilt_sin_x), .tilt_sin_y(tilt_sin_y),
    .map_sin_x(map_sin_x), .map_sin_y(map_sin_y), .map_x(map_x), .map_y(map_y),
    .map_x_out(map_x_out), .map_y_out(map_y_out), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_tx(pix_tx),
    .pix_ty(pix_ty), .pix_oob(pix_oob), .pix_last(pix_last), .busy(busy),
    .frame_done(frame_done), .frame_overrun(frame_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_tready"}, 32'(tilt_ready), 1);
    chk({tag, "_sinx"}, 32'(map_sin_x), 0);
    chk({tag, "_mapx"}, 32'(map_x), 0);
    chk({tag, "_pixx"}, 32'({pix_x, pix_y, pix_tx}), 0);
    chk({tag, "_flags"}, 32'({pix_oob, pix_last, frame_done}), 0);
  endtask

  // Runs one frame from frame_start (cycle N = iteration 0) to frame_done.
  task automatic run_frame(input bit toggle, input bit poke_mid, input bit poke_done,
                           input bit tilt_scan, input bit tilt_load,
                           input int exp_sin, input bit chk_len);
    int e = 0;
    int cyc = 0;
    bit done = 0;
    bit hold = 0;
    logic [10:0] sx = '0, sy = '0, stx = '0;
    int ex, ey;
    frame_start = 1'b1;
    pix_ready   = 1'b1;
    #1;
    chk("start_idle_busy", 32'(busy), 0);
    chk("start_idle_ovr", 32'(frame_overrun), 0);
    while (!done && cyc < int'(BUDGET)) begin
      @(posedge clk); #1;
      cyc++;
      frame_start = 1'b0;
      tilt_valid  = 1'b0;
      pix_ready   = toggle ? ~pix_ready : 1'b1;
      if (tilt_load && cyc == 1) begin
        tilt_valid = 1'b1; tilt_sin_x = 11'd70; tilt_sin_y = 11'd35;
      end
      if (tilt_scan && cyc == 12) begin
        tilt_valid = 1'b1; tilt_sin_x = 11'd50; tilt_sin_y = 11'd25;
      end
      if (poke_mid && cyc == 10) frame_start = 1'b1;
      #1;
      if (cyc == 1) chk("load_busy", 32'(busy), 1);
      if (cyc == 2) begin
        chk("act_sin_x", 32'(map_sin_x), 32'(exp_sin));
        chk("act_sin_y", 32'(map_sin_y), 32'(exp_sin / 2));
      end
      if (cyc == 3) chk("scan1_novalid", 32'(pix_valid), 0);
      if (cyc == 4) chk("first_beat_valid", 32'(pix_valid), 1);
      if (tilt_scan && cyc == 20) chk("no_tearing", 32'(map_sin_x), 32'(exp_sin));
      if (poke_mid && cyc == 10) chk("ovr_mid", 32'(frame_overrun), 1);
      if (hold) begin
        chk("hold_x", 32'(pix_x), 32'(sx));
        chk("hold_y", 32'(pix_y), 32'(sy));
        chk("hold_tx", 32'(pix_tx), 32'(stx));
      end
      if (pix_valid && pix_ready) begin
        ex = e % int'(W);
        ey = e / int'(W);
        chk("beat_x", 32'(pix_x), 32'(ex));
        chk("beat_y", 32'(pix_y), 32'(ey));
        chk("beat_tx", 32'(pix_tx), (ex >= int'(OOB_X)) ? 32'd1024 : 32'(ex + 16));
        chk("beat_ty", 32'(pix_ty), 32'(ey + 32));
        chk("beat_oob", 32'(pix_oob), (ex >= int'(OOB_X)) ? 32'd1 : 32'd0);
        chk("beat_last", 32'(pix_last), (e == int'(W * H) - 1) ? 32'd1 : 32'd0);
        e++;
      end
      if (frame_done) begin
        done = 1'b1;
        chk("done_on_last_hs", 32'(pix_valid && pix_ready && pix_last), 1);
        chk("beat_count", 32'(e), 32'(W * H));
        if (chk_len) chk("frame_len", 32'(cyc + 1), 32'(3 + S + W * H));
        if (poke_done) begin
          frame_start = 1'b1;
          #1;
          chk("ovr_on_done", 32'(frame_overrun), 1);
        end
      end
      hold = pix_valid && !pix_ready;
      sx = pix_x; sy = pix_y; stx = pix_tx;
    end
    if (!done) chk("frame_timeout", 0, 1);
    @(posedge clk); #1;
    frame_start = 1'b0;
    pix_ready   = 1'b1;
    #1;
    chk("post_idle_busy", 32'(busy), 0);
    chk("post_idle_valid", 32'(pix_valid), 0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; frame_start = 1'b0; tilt_valid = 1'b0; pix_ready = 1'b1;
    tilt_sin_x = '0; tilt_sin_y = '0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tilt_valid = 1'b1; tilt_sin_x = 11'd100; tilt_sin_y = 11'd50;
    @(posedge clk); #1;
    tilt_valid = 1'b0;

    // Plain frame with tilt 100, exact length.
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100, 1'b1);
    // Toggling ready; sample 50 arrives mid-scan and must not leak in.
    run_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 100, 1'b0);
    // Next frame picks 50 up; overrun pulses mid-scan and on frame_done.
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 50, 1'b1);
    // Sample 70 offered in the LOAD cycle bypasses into active.
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 70, 1'b1);

    // Asynchronous reset mid-frame at beat (2,2).
    found = 1'b0;
    frame_start = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      if (pix_valid && pix_x == 11'd2 && pix_y == 11'd2) found = 1'b1;
    end
    chk("rst_beat_seen", 32'(found), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
